// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue; define IFQ_BYPASS_EN for the 0-cycle empty-queue bypass
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [DATA_W-1:0]        in_pc4,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [DATA_W-1:0]        out_pc4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [DATA_W-1:0] pc4_mem_q   [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              drop_err_q, drop_err_d;

    logic empty;
    logic bypass_vis;
    logic bypass_take;
    logic push;
    logic pop;

    // Handshake qualification; in_ready depends only on the registered count
    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q != FULL_CNT);
`ifdef IFQ_BYPASS_EN
        // Gated by rst_n so outputs stay quiet while reset is held
        bypass_vis = empty & ~flush & rst_n;
`else
        bypass_vis = 1'b0;
`endif
        // A bypassed entry consumed by decode this cycle is never stored
        bypass_take = bypass_vis & in_valid & out_ready;
        push        = in_valid & in_ready & ~flush & ~bypass_take;
        pop         = ~empty & out_ready & ~flush;
    end

    // Pointer, occupancy and sticky overflow next-state; flush wins over push/pop
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_err_d = drop_err_q | (in_valid & ~in_ready & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc4_mem_q[wr_ptr_q]   <= in_pc4;
        end
    end

    // Head presentation: stored entry, optional bypass, otherwise zeros
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc4   = '0;
        if (!empty) begin
            out_valid = 1'b1;
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc4   = pc4_mem_q[rd_ptr_q];
        end else if (bypass_vis) begin
            out_valid = in_valid;
            out_instr = in_instr;
            out_pc4   = in_pc4;
        end
        count    = count_q;
        drop_err = drop_err_q;
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;
    logic [2:0]  count;
    logic        drop_err;

    int tests;
    int fails;
    logic [31:0] model_q[$];
    logic [31:0] exp_w;

    if_id_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .out_ready (out_ready),
        .count     (count),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc4    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // single push, visible after the edge
        in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc4 = 32'h4;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_instr", 64'(out_instr), 64'h13);
        chk("t1_out_pc4", 64'(out_pc4), 64'h4);
        chk("t1_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_pop_count", 64'(count), 64'd0);
        chk("t1_pop_valid", 64'(out_valid), 64'd0);
        chk("t1_pop_instr", 64'(out_instr), 64'd0);

        // underflow: pop on empty does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("uf_count", 64'(count), 64'd0);
        chk("uf_valid", 64'(out_valid), 64'd0);

        // fill to full, fifth push overflows
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hA0 + 32'(i);
            in_pc4   = 32'h100 + 32'(4 * i);
            if (i == 4) chk("t2_drop_before", 64'(drop_err), 64'd0);
            tick();
            chk($sformatf("t2_count_%0d", i), 64'(count), 64'((i < 4) ? i + 1 : 4));
        end
        in_valid = 1'b0;
        chk("t2_in_ready_full", 64'(in_ready), 64'd0);
        chk("t2_drop_err", 64'(drop_err), 64'd1);
        chk("t2_head_a0", 64'(out_instr), 64'hA0);
        chk("t2_head_pc4", 64'(out_pc4), 64'h100);

        // full queue, push and pop together: pop only
        in_valid = 1'b1; in_instr = 32'hBB; in_pc4 = 32'hBB;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t3_count", 64'(count), 64'd3);
        chk("t3_in_ready", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_order_%0d", i), 64'(out_instr), 64'(32'hA0 + 32'(i)));
            chk($sformatf("t2_pc4_%0d", i), 64'(out_pc4), 64'(32'h100 + 32'(4 * i)));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("t3_empty_count", 64'(count), 64'd0);
        chk("t3_drop_sticky", 64'(drop_err), 64'd1);

        // steady push+pop at count 2; pointers wrap three times
        model_q.delete();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = 32'hC000_0000 + 32'(k); in_pc4 = 32'(k);
            model_q.push_back(in_instr);
            tick();
        end
        chk("t4_pre_count", 64'(count), 64'd2);
        for (int k = 2; k < 14; k++) begin
            in_valid = 1'b1; in_instr = 32'hC000_0000 + 32'(k); in_pc4 = 32'(k);
            out_ready = 1'b1;
            exp_w = model_q.pop_front();
            chk($sformatf("t4_head_%0d", k), 64'(out_instr), 64'(exp_w));
            model_q.push_back(in_instr);
            tick();
            chk($sformatf("t4_count_%0d", k), 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        // count 3 then flush with in_valid and out_ready
        in_valid = 1'b1; in_instr = 32'hC000_000E; in_pc4 = 32'hE;
        tick();
        chk("t5_pre_count", 64'(count), 64'd3);
        in_instr = 32'hDEAD; flush = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_instr", 64'(out_instr), 64'd0);
        chk("t5_drop_err", 64'(drop_err), 64'd1);

        // async reset mid-stream at count 2
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = 32'hD0 + 32'(k); in_pc4 = 32'hD4;
            tick();
        end
        in_valid = 1'b0;
        chk("t6_pre_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_instr", 64'(out_instr), 64'd0);
        chk("t6_out_pc4", 64'(out_pc4), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_drop_err", 64'(drop_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // flush on a full queue with in_valid must not set drop_err
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = 32'hE0 + 32'(k); in_pc4 = 32'hE4;
            tick();
        end
        chk("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_drop_err", 64'(drop_err), 64'd0);

        // pointers restart at zero after flush
        in_valid = 1'b1; in_instr = 32'hF00D; in_pc4 = 32'hF4;
        tick();
        in_valid = 1'b0;
        chk("fl_post_instr", 64'(out_instr), 64'hF00D);
        chk("fl_post_pc4", 64'(out_pc4), 64'hF4);
        chk("fl_post_count", 64'(count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
